debounce_bank: RTL and testbench

Parametrised multi-channel debouncer for the traffic light controller's push-button and switch inputs (reset, walk request, reprogram and future buttons). Each channel synchronises an asynchronous input, filters it with a stability counter, and produces a clean level, single-cycle rise and fall pulses, and a long-press "held" flag. It sits between the board pins and the controller FSM, replacing the fixed three-instance debouncer wrapper with one block sized by parameter.

---
 rtl/tlc_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 88 ++++++++
 rtl/debounce_bank.sv | 42 ++++
 tb/tb_debounce_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared constants for the traffic light controller.
// Contents:
//   - button channel indices and the number of buttons
//   - board clock frequency and default debounce timing derived from it
//   - a helper converting milliseconds to clock cycles
package tlc_pkg;

    localparam int CLK_HZ    = 50_000_000;
    localparam int N_BUTTONS = 3;

    localparam int CH_RESET  = 0;
    localparam int CH_WALK   = 1;
    localparam int CH_REPROG = 2;

    typedef logic [N_BUTTONS-1:0] button_vec_t;

    // Milliseconds to clock cycles at the board clock.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    // 10 ms of stability filters typical contact bounce; a 2 s hold marks
    // a deliberate long press (used for reprogramming).
    localparam int DB_STABLE_CYCLES = ms_to_cycles(10);
    localparam int DB_HOLD_CYCLES   = ms_to_cycles(2000);

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel.
// Ports:
//   clk, sys_reset : clock and synchronous active-high reset
//   noisy          : raw asynchronous input
//   clean          : debounced level
//   rise, fall     : registered one-cycle pulses on clean 0->1 / 1->0
//   held           : high once clean has been high HOLD_CYCLES cycles
//                    (constant 0 when HOLD_CYCLES == 0)
module debounce_channel #(
    parameter int STABLE_CYCLES = 500000,
    parameter int HOLD_CYCLES   = 0
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic noisy,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic held
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic          s1_reg, s2_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [HW-1:0] hcnt_reg, hcnt_next;
    logic          clean_reg, clean_next;
    logic          rise_reg, rise_next;
    logic          fall_reg, fall_next;

    always_comb begin
        cnt_next   = '0;
        clean_next = clean_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s2_reg != clean_reg) begin
            if (cnt_reg == CNT_LAST) begin
                // Disagreement has lasted STABLE_CYCLES samples: accept it.
                clean_next = s2_reg;
                rise_next  = s2_reg;
                fall_next  = ~s2_reg;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Hold counter looks at clean_next so held drops on the very edge clean
    // falls, and only starts counting the edge after clean has risen.
    always_comb begin
        hcnt_next = hcnt_reg;
        if (!clean_next) begin
            hcnt_next = '0;
        end else if (clean_reg && (hcnt_reg != HOLD_MAX)) begin
            hcnt_next = hcnt_reg + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            cnt_reg   <= '0;
            hcnt_reg  <= '0;
            clean_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            s1_reg    <= noisy;
            s2_reg    <= s1_reg;
            cnt_reg   <= cnt_next;
            hcnt_reg  <= hcnt_next;
            clean_reg <= clean_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign clean = clean_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;
    assign held  = (HOLD_CYCLES != 0) && (hcnt_reg == HOLD_MAX);

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounce channels for push-buttons/switches.
// Ports:
//   clk, sys_reset : clock and synchronous active-high reset
//   noisy_in       : raw asynchronous inputs, bit i = channel i
//   clean_out      : debounced levels
//   rise_out       : one-cycle pulse per channel on clean 0->1
//   fall_out       : one-cycle pulse per channel on clean 1->0
//   held_out       : long-press flag per channel (0 if HOLD_CYCLES == 0)
module debounce_bank
    import tlc_pkg::*;
#(
    parameter int N_CH          = N_BUTTONS,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = 0
) (
    input  logic            clk,
    input  logic            sys_reset,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out,
    output logic [N_CH-1:0] held_out
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .HOLD_CYCLES  (HOLD_CYCLES)
            ) u_ch (
                .clk      (clk),
                .sys_reset(sys_reset),
                .noisy    (noisy_in[gi]),
                .clean    (clean_out[gi]),
                .rise     (rise_out[gi]),
                .fall     (fall_out[gi]),
                .held     (held_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    localparam int N = 3;
    localparam int S = 4;
    localparam int H = 8;

    logic         clk = 1'b0;
    logic         sys_reset;
    logic [N-1:0] noisy_in;
    logic [N-1:0] clean_out, rise_out, fall_out, held_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH(N), .STABLE_CYCLES(S), .HOLD_CYCLES(H)
    ) dut (
        .clk      (clk),
        .sys_reset(sys_reset),
        .noisy_in (noisy_in),
        .clean_out(clean_out),
        .rise_out (rise_out),
        .fall_out (fall_out),
        .held_out (held_out)
    );

    // Reference model: the input reaches the filter two edges late; the
    // clean level flips on an edge when the last S filter samples (including
    // the one seen at this edge) all disagree with it. held = clean has been
    // high for at least H edges since it rose.
    bit           del1 [N];
    bit           del2 [N];
    bit           hist [N][S];
    int           age  [N];
    logic [N-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_held = '0;

    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (sys_reset) begin
                del1[c] = 0; del2[c] = 0; age[c] = 0;
                for (int k = 0; k < S; k++) hist[c][k] = 0;
                m_clean[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_held[c] = 0;
            end else begin
                bit all_diff;
                for (int k = S - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
                hist[c][0] = del2[c];
                all_diff = 1;
                for (int k = 0; k < S; k++)
                    if (hist[c][k] == m_clean[c]) all_diff = 0;
                m_rise[c] = 0;
                m_fall[c] = 0;
                if (all_diff) begin
                    m_clean[c] = ~m_clean[c];
                    m_rise[c]  = m_clean[c];
                    m_fall[c]  = ~m_clean[c];
                    age[c]     = 0;
                end else if (m_clean[c]) begin
                    age[c] = age[c] + 1;
                end
                if (!m_clean[c]) age[c] = 0;
                m_held[c] = m_clean[c] && (age[c] >= H);
                del2[c] = del1[c];
                del1[c] = noisy_in[c];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clean", 32'(clean_out), 32'(m_clean));
            check("model_rise",  32'(rise_out),  32'(m_rise));
            check("model_fall",  32'(fall_out),  32'(m_fall));
            check("model_held",  32'(held_out),  32'(m_held));
            check("rise_fall_excl", 32'(rise_out & fall_out), 32'(0));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        sys_reset = 1'b1;
        noisy_in  = 3'b111;
        @(posedge clk);
        chk_en = 1;
        // Reset held with all inputs high: everything stays 0.
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("reset_clean", 32'(clean_out), 32'(0));
            check("reset_pulses", 32'(rise_out | fall_out | held_out), 32'(0));
            $display("[TB] reset cycle %0d clean=%b", i, clean_out);
        end
        sys_reset = 1'b0;
        step(5);
        check("release_e4_clean", 32'(clean_out), 32'(0));
        step(1);
        check("release_e5_clean", 32'(clean_out), 32'(3'b111));
        check("release_e5_rise",  32'(rise_out),  32'(3'b111));
        step(1);
        check("release_e6_rise",  32'(rise_out),  32'(0));
        step(6);
        check("hold_r7", 32'(held_out), 32'(0));
        step(1);
        check("hold_r8", 32'(held_out), 32'(3'b111));
        $display("[TB] reset release: clean=%b held=%b", clean_out, held_out);

        noisy_in = 3'b000;
        step(5);
        check("all_fall_e5_before", 32'(clean_out), 32'(3'b111));
        step(1);
        check("all_fall_e5", 32'(fall_out), 32'(3'b111));
        check("all_fall_held", 32'(held_out), 32'(0));
        step(10);
        $display("[TB] all released: clean=%b", clean_out);

        // Clean press/release on ch1.
        noisy_in = 3'b010;
        step(5);
        check("press_e4", 32'(clean_out[1]), 32'(0));
        step(1);
        check("press_e5_clean", 32'(clean_out), 32'(3'b010));
        check("press_e5_rise",  32'(rise_out),  32'(3'b010));
        step(1);
        check("press_e6_rise", 32'(rise_out), 32'(0));
        noisy_in = 3'b000;
        step(5);
        check("rel_e4_fall", 32'(fall_out), 32'(0));
        step(1);
        check("rel_e5_fall",  32'(fall_out),  32'(3'b010));
        check("rel_e5_clean", 32'(clean_out), 32'(0));
        $display("[TB] ch1 press/release done");
        step(3);

        // Bounce on ch0: high 3, low 1, high 2, low.
        noisy_in = 3'b001; step(3);
        noisy_in = 3'b000; step(1);
        noisy_in = 3'b001; step(2);
        noisy_in = 3'b000; step(10);
        check("bounce_clean", 32'(clean_out), 32'(0));
        $display("[TB] bounce ch0: clean=%b", clean_out);

        // Long press on ch2.
        noisy_in = 3'b100;
        step(6);
        check("long_rise", 32'(rise_out), 32'(3'b100));
        step(7);
        check("long_r7", 32'(held_out), 32'(0));
        step(1);
        check("long_r8", 32'(held_out), 32'(3'b100));
        step(5);
        noisy_in = 3'b000;
        step(5);
        check("long_rel_e4_held", 32'(held_out), 32'(3'b100));
        step(1);
        check("long_rel_e5_held", 32'(held_out), 32'(0));
        check("long_rel_e5_fall", 32'(fall_out), 32'(3'b100));
        $display("[TB] long press ch2 done");
        step(3);

        // Simultaneous: ch0 rises while ch1 falls.
        noisy_in = 3'b010;
        step(10);
        noisy_in = 3'b001;
        step(6);
        check("simul_rise", 32'(rise_out), 32'(3'b001));
        check("simul_fall", 32'(fall_out), 32'(3'b010));
        $display("[TB] simultaneous: rise=%b fall=%b", rise_out, fall_out);
        step(3);

        // Mid-debounce reset on ch1.
        noisy_in = 3'b000;
        step(10);
        noisy_in = 3'b010;
        step(5);
        sys_reset = 1'b1;
        step(1);
        sys_reset = 1'b0;
        step(5);
        check("midrst_e4", 32'(clean_out), 32'(0));
        step(1);
        check("midrst_e5_clean", 32'(clean_out), 32'(3'b010));
        check("midrst_e5_rise",  32'(rise_out),  32'(3'b010));
        $display("[TB] mid-debounce reset: clean=%b", clean_out);
        step(3);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
